fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
// - Parametrised F-stage successor: owns the fetch PC, reads the instruction ROM each cycle and buffers {PC, Instr} pairs in a DEPTH-entry FIFO.
// - D stage pops entries through a valid/ready handshake, so a D-side stall never stops fetch until the queue is full.
// - A D-side redirect (branch/jump target) flushes the queue and retargets fetch in one cycle.
// PARAMETERS
// - RESET_PC   32'h0000_3000  fetch PC loaded on reset
// - DEPTH      4              queue entries; power of 2, >= 2
// - IM_BASE    32'h0000_3000  lowest legal instruction address (range check only)
// - IM_WORDS   4096           instruction ROM size in words (range check only)
// PORTS
// - clk            in   1   sole clock, rising edge
// - reset          in   1   synchronous, active-high
// - imem_addr      out  32  ROM word address = fetch_pc; ROM is combinational
// - imem_rdata     in   32  instruction at imem_addr, valid in the same cycle
// - d_redirect     in   1   flush queue and retarget fetch
// - d_target       in   32  new fetch PC, sampled when d_redirect=1
// - d_ready        in   1   D accepts head entry this cycle
// - f_valid        out  1   head entry present (count != 0)
// - f_PC           out  32  head entry PC; 0 when empty
// - f_Instr        out  32  head entry instruction; 0 when empty
// - f_exc_adel     out  1   head entry fetch-address fault (see CONFIGURATION)
// BEHAVIOUR
// - Reset: fetch_pc=RESET_PC, wr_ptr=rd_ptr=0, count=0; f_valid=0, f_PC=0, f_Instr=0, f_exc_adel=0.
// - pop = f_valid & d_ready; push = ~d_redirect & (count<DEPTH | pop).
// - Push: entry[wr_ptr] <= {fetch_pc, imem_rdata, exc}; wr_ptr+1; fetch_pc <= fetch_pc+4 (mod 2^32).
// - Pop: rd_ptr+1. Simultaneous push and pop: count unchanged; allowed when full.
// - Pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
// - Full (count==DEPTH) without pop: no push, fetch_pc held, imem_addr still driven.
// - Empty: f_valid=0; d_ready ignored, no pop.
// - Redirect wins over everything: next cycle count=0, pointers=0, fetch_pc=d_target; any same-cycle pop/push discarded.
// - Delay-slot handling is D's job: D asserts d_redirect only after it has accepted the delay slot.
// - Latency: entry pushed in cycle N is visible at f_PC/f_Instr in N+1; no fall-through bypass.
// - After reset release or redirect: first f_valid one cycle later; steady state 1 entry/cycle.
// - Outputs are registered-storage reads muxed by rd_ptr; no combinational path d_ready -> f_valid.
// - Reset mid-operation discards all entries and has priority over d_redirect.
// CONFIGURATION
// - Macro FETCH_ADDR_CHECK_EN.
// - Defined: exc = fetch_pc[1:0]!=0 | fetch_pc<IM_BASE | fetch_pc>=IM_BASE+4*IM_WORDS;
//   faulting entry stores Instr=32'h0 (nop) and exc=1; fetch continues (PC+4) until redirect.
// - Not defined: no check, Instr always imem_rdata, f_exc_adel tied 0, exc bit not stored.
// STRUCTURE
// - Shared package fetch_pkg: RESET_PC/IM_BASE defaults, NOP_INSTR=32'h0, entry field widths.
// - Sub-module fetch_fifo (DEPTH, WIDTH): storage, pointers, count, flush input; top keeps fetch_pc, push/pop logic, address check.
// TESTING
// - Reset, d_ready=1, ROM[i]=i+1: f_PC 0x3000,0x3004,... from cycle 1, f_Instr 1,2,... one per cycle.
// - d_ready=0 for 10 cycles: count saturates at 4, fetch_pc holds 0x3010; release -> 0x3000..0x300c in order, no loss/duplication.
// - Full queue, d_ready=1: pop+push same cycle, count stays 4, one entry/cycle throughput.
// - d_redirect=1, d_target=0x3100 with 3 entries queued and d_ready=1: next cycle f_valid=0; following cycle f_PC=0x3100.
// - reset asserted with 2 entries and redirect pending: next cycle f_valid=0, imem_addr=0x3000.
// - FETCH_ADDR_CHECK_EN, d_target=0x3102: f_exc_adel=1, f_Instr=0; without macro f_exc_adel=0, f_Instr=ROM word.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the prefetching fetch stage.
// Defining FETCH_ADDR_CHECK_EN widens each queue entry with a fetch-address fault bit.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [PC_W-1:0]    IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int                 IM_WORDS_DEFAULT = 4096;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

`ifdef FETCH_ADDR_CHECK_EN
  localparam int ENTRY_W = PC_W + INSTR_W + 1;
`else
  localparam int ENTRY_W = PC_W + INSTR_W;
`endif
endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle between the fetch queue, the instruction ROM and the decode stage.
// master = fetch queue side, slave = ROM/decode environment side.
interface fetch_prefetch_queue_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               d_redirect;
  logic [PC_W-1:0]    d_target;
  logic               d_ready;
  logic               f_valid;
  logic [PC_W-1:0]    f_PC;
  logic [INSTR_W-1:0] f_Instr;
  logic               f_exc_adel;

  modport master (
    output imem_addr, f_valid, f_PC, f_Instr, f_exc_adel,
    input  imem_rdata, d_redirect, d_target, d_ready
  );

  modport slave (
    input  imem_addr, f_valid, f_PC, f_Instr, f_exc_adel,
    output imem_rdata, d_redirect, d_target, d_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO with occupancy count and a synchronous flush.
// Head data reads as zero whenever the queue is empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage that owns the PC and prefetches {PC, Instr} pairs into a queue for decode.
// Build with FETCH_ADDR_CHECK_EN to flag misaligned/out-of-range fetches as nop entries.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int              IM_WORDS = IM_WORDS_DEFAULT
) (
  input logic                    clk,
  input logic                    reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int              CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IM_WORDS < 1 || IM_BASE[1:0] != 2'b00)
  begin : g_bad_config
    $error("fetch_prefetch_queue: unsupported DEPTH/IM_BASE/IM_WORDS");
  end

  logic [PC_W-1:0]    fetch_pc;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign pop           = bus.f_valid & bus.d_ready;
  assign push          = ~bus.d_redirect & ((count < FULL_COUNT) | pop);
  assign bus.imem_addr = fetch_pc;
  assign bus.f_valid   = (count != '0);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [PC_W-1:0] IM_LIMIT = IM_BASE + PC_W'(4 * IM_WORDS);
  logic exc;

  // Faulting fetches still occupy a slot so decode sees the fault in program order.
  assign exc      = (fetch_pc[1:0] != 2'b00) | (fetch_pc < IM_BASE) | (fetch_pc >= IM_LIMIT);
  assign wr_entry = {exc, fetch_pc, exc ? NOP_INSTR : bus.imem_rdata};
  assign {bus.f_exc_adel, bus.f_PC, bus.f_Instr} = rd_entry;
`else
  assign wr_entry       = {fetch_pc, bus.imem_rdata};
  assign {bus.f_PC, bus.f_Instr} = rd_entry;
  assign bus.f_exc_adel = 1'b0;
`endif

  // Redirect retargets fetch immediately; reset outranks it.
  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (bus.d_redirect) fetch_pc <= bus.d_target;
    else if (push)           fetch_pc <= fetch_pc + PC_W'(4);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.d_redirect),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count)
  );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: table-driven streaming/stall vectors plus
// hand sequences for redirect, reset priority and address faults (FETCH_ADDR_CHECK_EN aware).
module tb_fetch_prefetch_queue;
`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        redirect;
    logic [31:0] target;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  logic   clk;
  logic   reset;
  int     n_compared;
  int     n_mismatched;
  vec_t   vecs[$];

  fetch_prefetch_queue_if bus ();

  fetch_prefetch_queue u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return ((addr - 32'h0000_3000) >> 2) + 32'd1;
  endfunction

  // ROM[i] = i+1, combinational on the fetch address
  always_comb bus.imem_rdata = rom_word(bus.imem_addr);

  function automatic void add_vec(input logic r, input logic d, input logic [31:0] t,
                                  input logic rdy, input logic ev, input logic [31:0] ep,
                                  input logic [31:0] ei, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.redirect = d; v.target = t; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei; v.exp_addr = ea;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then land on the following falling edge
  task automatic apply_stimulus(input logic r, input logic d, input logic [31:0] t,
                                input logic rdy);
    reset          = r;
    bus.d_redirect = d;
    bus.d_target   = t;
    bus.d_ready    = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei, input logic ee, input logic [31:0] ea);
    compare($sformatf("%s f_valid", name), {31'd0, bus.f_valid}, {31'd0, ev});
    compare($sformatf("%s f_PC", name), bus.f_PC, ep);
    compare($sformatf("%s f_Instr", name), bus.f_Instr, ei);
    compare($sformatf("%s f_exc_adel", name), {31'd0, bus.f_exc_adel}, {31'd0, ee});
    compare($sformatf("%s imem_addr", name), bus.imem_addr, ea);
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    reset          = 1'b1;
    bus.d_redirect = 1'b0;
    bus.d_target   = 32'h0;
    bus.d_ready    = 1'b0;

    // streaming from reset, empty queue ignores d_ready
    add_vec(1, 0, 0, 0, 0, 32'h0,    32'h0, 32'h3000);
    add_vec(0, 0, 0, 1, 1, 32'h3000, 32'h1, 32'h3004);
    add_vec(0, 0, 0, 1, 1, 32'h3004, 32'h2, 32'h3008);
    add_vec(0, 0, 0, 1, 1, 32'h3008, 32'h3, 32'h300c);
    // ten-cycle stall: queue fills to 4, fetch holds at 0x3010
    add_vec(1, 0, 0, 0, 0, 32'h0,    32'h0, 32'h3000);
    add_vec(0, 0, 0, 0, 1, 32'h3000, 32'h1, 32'h3004);
    add_vec(0, 0, 0, 0, 1, 32'h3000, 32'h1, 32'h3008);
    add_vec(0, 0, 0, 0, 1, 32'h3000, 32'h1, 32'h300c);
    for (int k = 0; k < 7; k++)
      add_vec(0, 0, 0, 0, 1, 32'h3000, 32'h1, 32'h3010);
    // release while full: pop+push each cycle
    add_vec(0, 0, 0, 1, 1, 32'h3004, 32'h2, 32'h3014);
    add_vec(0, 0, 0, 1, 1, 32'h3008, 32'h3, 32'h3018);
    add_vec(0, 0, 0, 1, 1, 32'h300c, 32'h4, 32'h301c);
    add_vec(0, 0, 0, 1, 1, 32'h3010, 32'h5, 32'h3020);
    add_vec(0, 0, 0, 1, 1, 32'h3014, 32'h6, 32'h3024);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].redirect, vecs[i].target, vecs[i].ready);
      check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                   vecs[i].exp_instr, 1'b0, vecs[i].exp_addr);
    end

    // redirect with three entries queued and d_ready=1
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("three_queued", 1, 32'h3000, 32'h1, 0, 32'h300c);
    apply_stimulus(0, 1, 32'h3100, 1);
    check_output("redir_flush", 0, 32'h0, 32'h0, 0, 32'h3100);
    apply_stimulus(0, 0, 0, 1);
    check_output("redir_first", 1, 32'h3100, 32'h41, 0, 32'h3104);

    // reset beats a pending redirect with two entries queued
    apply_stimulus(0, 0, 0, 0);
    check_output("two_queued", 1, 32'h3100, 32'h41, 0, 32'h3108);
    apply_stimulus(1, 1, 32'h3200, 1);
    check_output("reset_wins", 0, 32'h0, 32'h0, 0, 32'h3000);
    apply_stimulus(0, 0, 0, 1);
    check_output("after_reset", 1, 32'h3000, 32'h1, 0, 32'h3004);

    // misaligned target
    apply_stimulus(0, 1, 32'h3102, 1);
    check_output("mis_flush", 0, 32'h0, 32'h0, 0, 32'h3102);
    apply_stimulus(0, 0, 0, 1);
    check_output("mis_0", 1, 32'h3102, CHECK_EN ? 32'h0 : 32'h41, CHECK_EN, 32'h3106);
    apply_stimulus(0, 0, 0, 1);
    check_output("mis_1", 1, 32'h3106, CHECK_EN ? 32'h0 : 32'h42, CHECK_EN, 32'h310a);

    // just below IM_BASE, then fetch continues into legal space
    apply_stimulus(0, 1, 32'h2ffc, 1);
    check_output("low_flush", 0, 32'h0, 32'h0, 0, 32'h2ffc);
    apply_stimulus(0, 0, 0, 1);
    check_output("low_0", 1, 32'h2ffc, CHECK_EN ? 32'h0 : rom_word(32'h2ffc), CHECK_EN,
                 32'h3000);
    apply_stimulus(0, 0, 0, 1);
    check_output("low_1", 1, 32'h3000, 32'h1, 0, 32'h3004);

    // last legal word, then first word past the ROM
    apply_stimulus(0, 1, 32'h6ffc, 1);
    apply_stimulus(0, 0, 0, 1);
    check_output("top_last", 1, 32'h6ffc, 32'h1000, 0, 32'h7000);
    apply_stimulus(0, 0, 0, 1);
    check_output("top_past", 1, 32'h7000, CHECK_EN ? 32'h0 : 32'h1001, CHECK_EN, 32'h7004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
